// File: rtl/accum_4b_rtl.sv
// accum_4b_rtl: 4-bit streaming accumulator with a valid/ready handshake.
// A 2:1 mux feeds the accumulator register. It picks the raw operand for the
// first operand of a stream, and the adder output for every later operand.
// An operand counter saturates at 15. An overflow flag records any carry out
// of bit 3 during the stream.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_rdy is a function of state and reset only. out_val is a function of
// state only. Neither depends on in_* or out_rdy in the same cycle.
module accum_4b_rtl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [3:0] out_data,
  output logic       out_ovf,
  output logic [3:0] out_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_acc;
  logic        r_ovf;
  logic [3:0]  r_cnt;

  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_mux_sel;
  logic [4:0]  w_sum;
  logic [3:0]  w_mux;
  logic        w_load;
  logic [3:0]  w_acc_nxt;
  logic        w_ovf_nxt;
  logic [3:0]  w_cnt_nxt;

  assign in_rdy     = (r_state != S_DONE) & ~reset;
  assign out_val    = (r_state == S_DONE);
  assign out_data   = r_acc;
  assign out_ovf    = r_ovf;
  assign out_cnt    = r_cnt;
  assign dbg_state  = r_state;

  assign w_in_xfer  = in_val & in_rdy;
  assign w_out_xfer = out_val & out_rdy;

  // Datapath: the adder keeps the carry bit, and the mux picks operand or sum
  assign w_mux_sel  = (r_state == S_ACCUM);
  assign w_sum      = {1'b0, r_acc} + {1'b0, in_data};
  assign w_mux      = w_mux_sel ? w_sum[3:0] : in_data;

  // Next-state and register-update decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_in_xfer) begin
          w_load      = 1'b1;
          w_acc_nxt   = w_mux;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = in_last ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_in_xfer) begin
          w_load      = 1'b1;
          w_acc_nxt   = w_mux;
          w_ovf_nxt   = r_ovf | w_sum[4];
          w_cnt_nxt   = (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;
          w_state_nxt = in_last ? S_DONE : S_ACCUM;
        end
      end
      S_DONE: begin
        // The result stays in acc/ovf/cnt until the next first operand overwrites it
        if (w_out_xfer) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, overflow flag and operand counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= 4'd0;
      r_ovf <= 1'b0;
      r_cnt <= 4'd0;
    end else if (w_load) begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule
